// File: rtl/axi_mem_arbiter.sv
// Two-port round-robin arbiter that turns 32-bit word requests into single
// 128-bit AXI transactions, one outstanding at a time. Write data is
// replicated across all four word lanes and qualified by a shifted strobe;
// read data is taken from the lane selected by addr[3:2].
module axi_mem_arbiter (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         p0_req,
    input  logic [31:0]  p0_addr,
    input  logic [31:0]  p0_wdata,
    input  logic [3:0]   p0_we,
    output logic         p0_gnt,
    output logic [31:0]  p0_rdata,
    output logic         p0_valid,

    input  logic         p1_req,
    input  logic [31:0]  p1_addr,
    input  logic [31:0]  p1_wdata,
    input  logic [3:0]   p1_we,
    output logic         p1_gnt,
    output logic [31:0]  p1_rdata,
    output logic         p1_valid,

    output logic [31:0]  m_awaddr,
    output logic         m_awvalid,
    input  logic         m_awready,
    output logic [127:0] m_wdata,
    output logic [15:0]  m_wstrb,
    output logic         m_wvalid,
    input  logic         m_wready,
    input  logic         m_bvalid,
    output logic         m_bready,

    output logic [31:0]  m_araddr,
    output logic         m_arvalid,
    input  logic         m_arready,
    input  logic [127:0] m_rdata,
    input  logic         m_rvalid,
    output logic         m_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        last_grant;     // port granted most recently
    logic        grant;
    logic        sel_port;
    logic [3:0]  sel_we;

    logic [29:0] cap_word_addr;  // captured addr[31:2]
    logic [31:0] cap_wdata;
    logic [3:0]  cap_we;
    logic        cap_port;
    logic [1:0]  lane;

    logic        aw_done;
    logic        w_done;
    logic        complete;

    // Byte-offset bits are architecturally ignored.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr[1:0], p1_addr[1:0]};

    assign lane      = cap_word_addr[1:0];
    assign m_awaddr  = {cap_word_addr, 2'b00};
    assign m_araddr  = {cap_word_addr, 2'b00};
    assign m_wdata   = {4{cap_wdata}};
    assign m_wstrb   = 16'(cap_we) << {lane, 2'b00};
    assign complete  = (state == WRESP && m_bvalid) || (state == RDATA && m_rvalid);

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
    // Gated by rst_n so no grant escapes while reset is held.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        grant    = 1'b0;
        sel_port = 1'b0;
        if (state == IDLE && rst_n) begin
            if (p0_req && p1_req) begin
                grant    = 1'b1;
                sel_port = ~last_grant;
            end else if (p0_req) begin
                grant    = 1'b1;
                sel_port = 1'b0;
            end else if (p1_req) begin
                grant    = 1'b1;
                sel_port = 1'b1;
            end
        end
    end

    assign p0_gnt = grant && !sel_port;
    assign p1_gnt = grant &&  sel_port;
    assign sel_we = sel_port ? p1_we : p0_we;

    // Next-state and AXI handshake outputs; all valids/readies low unless the state drives them.
    always_comb begin
        state_next = state;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_next = (sel_we != 4'd0) ? WADDR : RADDR;
            end
            WADDR: begin
                m_awvalid = !aw_done;
                m_wvalid  = !w_done;
                if ((aw_done || m_awready) && (w_done || m_wready)) state_next = WRESP;
            end
            WRESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_next = IDLE;
            end
            RADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_next = RDATA;
            end
            RDATA: begin
                m_rready = 1'b1;
                if (m_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Capture the winning request and remember who won, on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= 1'b1;
            cap_word_addr <= '0;
            cap_wdata     <= '0;
            cap_we        <= '0;
            cap_port      <= 1'b0;
        end else if (grant) begin
            last_grant    <= sel_port;
            cap_port      <= sel_port;
            cap_word_addr <= sel_port ? p1_addr[31:2] : p0_addr[31:2];
            cap_wdata     <= sel_port ? p1_wdata : p0_wdata;
            cap_we        <= sel_we;
        end
    end

    // Remember which write-channel handshakes are done so each valid drops on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state != WADDR) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (m_awvalid && m_awready) aw_done <= 1'b1;
            if (m_wvalid && m_wready)   w_done  <= 1'b1;
        end
    end

    // Per-port completion pulse and read-data holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the read-data holding registers are reset too, so they read 0 out of reset.
        if (!rst_n) begin
            p0_valid <= 1'b0;
            p1_valid <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_valid <= complete && !cap_port;
            p1_valid <= complete &&  cap_port;
            if (state == RDATA && m_rvalid) begin
                if (cap_port) p1_rdata <= m_rdata[{lane, 5'b00000} +: 32];
                else          p0_rdata <= m_rdata[{lane, 5'b00000} +: 32];
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: a table of single transactions with
// hand-computed AXI fields and read results, plus hand-written sequences
// for round-robin, withdrawn requests, spurious responses and mid-read reset.
module tb_axi_mem_arbiter;

    localparam logic [127:0] SRD_A = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    localparam logic [127:0] SRD_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         p0_req = 0, p1_req = 0;
    logic [31:0]  p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
    logic [3:0]   p0_we = 0, p1_we = 0;
    logic         p0_gnt, p1_gnt, p0_valid, p1_valid;
    logic [31:0]  p0_rdata, p1_rdata;
    logic [31:0]  m_awaddr, m_araddr;
    logic         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic         m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
    logic [127:0] m_rdata = '0;

    always #5 clk = ~clk;

    axi_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
        .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_valid(p0_valid),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
        .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_valid(p1_valid),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    typedef struct {
        string        name;
        bit           port;
        logic [31:0]  addr;
        logic [3:0]   we;
        logic [31:0]  wdata;
        logic [127:0] srd;        // slave read beat
        int           addr_delay; // cycles awready/arready is withheld
        int           w_delay;    // cycles wready is withheld
        logic [31:0]  exp_addr;
        logic [15:0]  exp_wstrb;
        logic [31:0]  exp_rdata;
    } vec_t;

    vec_t        vecs[7];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_rd[2];

    // observations from the last run_txn
    int           obs_gnt_lat, obs_addr_cycles, obs_w_cycles, obs_ar_cycles;
    int           obs_gnt_cnt[2], obs_valid_cnt[2];
    bit           obs_stable, obs_early_resp;
    logic [31:0]  obs_addr;
    logic [127:0] obs_wdata;
    logic [15:0]  obs_wstrb;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_port(input bit port, input logic req, input logic [31:0] addr,
                              input logic [3:0] we, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_addr = addr; p1_we = we; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_addr = addr; p0_we = we; p0_wdata = wdata;
        end
    endtask

    task automatic slave_idle();
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    // Zero-latency slave answering reads with a fixed beat.
    task automatic slave_auto(input logic [127:0] srd);
        m_arready = m_arvalid;
        m_rvalid  = m_rready;
        m_rdata   = srd;
        m_bvalid  = m_bready;
        m_awready = m_awvalid;
        m_wready  = m_wvalid;
    endtask

    // One request from one port against a slave that withholds its address/data readies.
    task automatic run_txn(input vec_t v);
        bit granted = 0, aw_hs = 0, w_hs = 0;
        int tail = 0;
        obs_gnt_lat = -1; obs_addr_cycles = 0; obs_w_cycles = 0; obs_ar_cycles = 0;
        obs_gnt_cnt = '{0, 0}; obs_valid_cnt = '{0, 0};
        obs_stable = 1; obs_early_resp = 0;
        obs_addr = 'x; obs_wdata = 'x; obs_wstrb = 'x;
        @(negedge clk);
        drive_port(v.port, 1'b1, v.addr, v.we, v.wdata);
        for (int c = 0; c < 60 && tail < 3; c++) begin
            if (c > 0) @(negedge clk);
            // after capture the request fields are scrambled to expose a missing capture
            if (granted) drive_port(v.port, 1'b0, ~v.addr, ~v.we, ~v.wdata);
            #1;
            if (p0_gnt) obs_gnt_cnt[0]++;
            if (p1_gnt) obs_gnt_cnt[1]++;
            if (!granted && (v.port ? p1_gnt : p0_gnt)) begin
                granted = 1; obs_gnt_lat = c;
            end
            if (m_bready && !(aw_hs && w_hs)) obs_early_resp = 1;
            if (m_awvalid) begin
                if (obs_addr_cycles == 0) obs_addr = m_awaddr;
                else if (m_awaddr !== obs_addr) obs_stable = 0;
                m_awready = (obs_addr_cycles >= v.addr_delay);
                if (m_awready) aw_hs = 1;
                obs_addr_cycles++;
            end else m_awready = 0;
            if (m_wvalid) begin
                if (obs_w_cycles == 0) begin obs_wdata = m_wdata; obs_wstrb = m_wstrb; end
                else if (m_wdata !== obs_wdata || m_wstrb !== obs_wstrb) obs_stable = 0;
                m_wready = (obs_w_cycles >= v.w_delay);
                if (m_wready) w_hs = 1;
                obs_w_cycles++;
            end else m_wready = 0;
            if (m_arvalid) begin
                if (obs_ar_cycles == 0) obs_addr = m_araddr;
                else if (m_araddr !== obs_addr) obs_stable = 0;
                m_arready = (obs_ar_cycles >= v.addr_delay);
                obs_ar_cycles++;
            end else m_arready = 0;
            m_bvalid = m_bready;
            m_rvalid = m_rready;
            m_rdata  = m_rready ? v.srd : ~v.srd;
            if (p0_valid) obs_valid_cnt[0]++;
            if (p1_valid) obs_valid_cnt[1]++;
            if (obs_valid_cnt[v.port] > 0) tail++;
        end
        slave_idle();
    endtask

    task automatic check_vec(input vec_t v);
        bit o;
        o = ~v.port;
        run_txn(v);
        check({v.name, " gnt_latency"}, obs_gnt_lat, 0);
        check({v.name, " gnt_count"}, obs_gnt_cnt[v.port], 1);
        check({v.name, " other_gnt"}, obs_gnt_cnt[o], 0);
        check({v.name, " valid_count"}, obs_valid_cnt[v.port], 1);
        check({v.name, " other_valid"}, obs_valid_cnt[o], 0);
        check({v.name, " addr_stable"}, obs_stable, 1);
        check({v.name, " axi_addr"}, obs_addr, v.exp_addr);
        if (v.we != 4'd0) begin
            check({v.name, " wstrb"}, obs_wstrb, v.exp_wstrb);
            check({v.name, " wdata"}, obs_wdata, {4{v.wdata}});
            check({v.name, " awvalid_cycles"}, obs_addr_cycles, v.addr_delay + 1);
            check({v.name, " wvalid_cycles"}, obs_w_cycles, v.w_delay + 1);
            check({v.name, " early_wresp"}, obs_early_resp, 0);
            check({v.name, " no_read"}, obs_ar_cycles, 0);
        end else begin
            check({v.name, " arvalid_cycles"}, obs_ar_cycles, v.addr_delay + 1);
            check({v.name, " no_write"}, obs_addr_cycles + obs_w_cycles, 0);
            model_rd[v.port] = v.exp_rdata;
        end
        check({v.name, " p0_rdata"}, p0_rdata, model_rd[0]);
        check({v.name, " p1_rdata"}, p1_rdata, model_rd[1]);
    endtask

    initial begin
        bit seq[$];
        int both_gnt = 0, cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_d = 0;

        vecs[0] = '{"rd_p0_0x40",   1'b0, 32'h0000_0040, 4'b0000, 32'h0,         SRD_A, 0, 0, 32'h0000_0040, 16'h0000, 32'hAAAA_AAAA};
        vecs[1] = '{"wr_p1_0x1c",   1'b1, 32'h0000_001C, 4'b0011, 32'h1234_5678, '0,    0, 0, 32'h0000_001C, 16'h3000, 32'h0};
        vecs[2] = '{"rd_p1_lane1",  1'b1, 32'h0000_0107, 4'b0000, 32'h0,         SRD_A, 0, 0, 32'h0000_0104, 16'h0000, 32'hBBBB_BBBB};
        vecs[3] = '{"wr_p0_aw_late",1'b0, 32'h2000_0008, 4'b1111, 32'hDEAD_BEEF, '0,    3, 0, 32'h2000_0008, 16'h0F00, 32'h0};
        vecs[4] = '{"wr_p0_w_late", 1'b0, 32'h0000_0004, 4'b1000, 32'hA5A5_5A5A, '0,    0, 3, 32'h0000_0004, 16'h0080, 32'h0};
        vecs[5] = '{"rd_p1_lane3",  1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h0,         SRD_B, 0, 0, 32'hFFFF_FFFC, 16'h0000, 32'h0123_4567};
        vecs[6] = '{"rd_p0_ar_late",1'b0, 32'h0000_0008, 4'b0000, 32'h0,         SRD_B, 2, 0, 32'h0000_0008, 16'h0000, 32'h89AB_CDEF};

        // ---- reset state, including requests presented while reset is held
        #3;
        p0_req = 1; p1_req = 1;
        #1;
        check("rst gnt", {p0_gnt, p1_gnt}, 2'b00);
        check("rst valid", {p0_valid, p1_valid}, 2'b00);
        check("rst axi_handshake", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
        check("rst rdata", {p0_rdata, p1_rdata}, 64'h0);
        p0_req = 0; p1_req = 0;
        #8 rst_n = 1;
        model_rd = '{32'h0, 32'h0};

        // ---- both ports request together and hold: grants must alternate p0,p1,p0,p1
        @(negedge clk);
        p0_addr = 32'h0; p0_we = 0; p1_addr = 32'h4; p1_we = 0;
        p0_req = 1; p1_req = 1;
        for (int c = 0; c < 80 && seq.size() < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (p0_gnt && p1_gnt) both_gnt++;
            if (p0_gnt) seq.push_back(1'b0);
            else if (p1_gnt) seq.push_back(1'b1);
            if (p0_valid) cnt_a++;
            if (p1_valid) cnt_b++;
            slave_auto(SRD_A);
        end
        @(negedge clk);
        p0_req = 0; p1_req = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (p0_valid) cnt_a++;
            if (p1_valid) cnt_b++;
            slave_auto(SRD_A);
            @(negedge clk);
        end
        slave_idle();
        check("rr grant_count", seq.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr grant%0d", i), (i < seq.size()) ? 2'(seq[i]) : 2'd3, 2'(i % 2));
        check("rr gnt_onehot", both_gnt, 0);
        check("rr p0_valids", cnt_a, 2);
        check("rr p1_valids", cnt_b, 2);
        check("rr p0_rdata", p0_rdata, 32'hAAAA_AAAA);
        check("rr p1_rdata", p1_rdata, 32'hBBBB_BBBB);
        model_rd = '{32'hAAAA_AAAA, 32'hBBBB_BBBB};

        // ---- table of single transactions
        for (int i = 0; i < 7; i++) check_vec(vecs[i]);

        // ---- p1 raises and withdraws its request while p0's read is stalled
        @(negedge clk);
        drive_port(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
        #1;
        check("wd p0_gnt", p0_gnt, 1'b1);
        @(negedge clk);
        p0_req = 0;
        drive_port(1'b1, 1'b1, 32'h20, 4'hF, 32'h5555_AAAA);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 2) p1_req = 0;
            #1;
            if (p1_gnt) cnt_b++;
            if (p0_valid) cnt_a++;
            if (p1_valid) cnt_c++;
            if (m_awvalid || m_wvalid) cnt_d++;
            // hold off the address handshake while p1 is requesting
            if (c < 3) slave_idle();
            else slave_auto(SRD_A);
            @(negedge clk);
        end
        slave_idle();
        check("wd p1_gnt", cnt_b, 0);
        check("wd p1_valid", cnt_c, 0);
        check("wd no_write", cnt_d, 0);
        check("wd p0_valid", cnt_a, 1);
        check("wd p0_rdata", p0_rdata, 32'hAAAA_AAAA);
        model_rd[0] = 32'hAAAA_AAAA;

        // ---- spurious read/write responses while idle
        cnt_a = 0;
        for (int c = 0; c < 3; c++) begin
            m_rvalid = 1; m_bvalid = 1; m_rdata = '1;
            @(negedge clk);
            #1;
            if (p0_valid || p1_valid) cnt_a++;
        end
        slave_idle();
        check("spur valid", cnt_a, 0);
        check("spur p0_rdata", p0_rdata, model_rd[0]);
        check("spur p1_rdata", p1_rdata, model_rd[1]);

        // ---- reset pulsed while waiting in RDATA
        @(negedge clk);
        drive_port(1'b0, 1'b1, 32'h38, 4'h0, 32'h0);
        #1;
        check("rstmid gnt", p0_gnt, 1'b1);
        @(negedge clk);
        p0_req = 0;
        #1;
        m_arready = m_arvalid;
        @(negedge clk);
        m_arready = 0;
        #1;
        check("rstmid in_rdata", m_rready, 1'b1);
        #1 rst_n = 0;
        #1;
        check("rstmid handshake", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
        check("rstmid valid", {p0_valid, p1_valid}, 2'b00);
        check("rstmid rdata", {p0_rdata, p1_rdata}, 64'h0);
        #1 rst_n = 1;
        model_rd = '{32'h0, 32'h0};
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 4; c++) begin
            m_rvalid = 1; m_rdata = SRD_A;
            @(negedge clk);
            #1;
            if (p0_valid || p1_valid) cnt_a++;
            if (m_rready || m_arvalid) cnt_b++;
        end
        slave_idle();
        check("rstmid no_valid", cnt_a, 0);
        check("rstmid idle", cnt_b, 0);
        check("rstmid p0_rdata", p0_rdata, 32'h0);
        check_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so a stuck design still terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
